// File: rtl/pwm_peripheral.sv
// 16-channel PWM peripheral: shared prescaler and 8-bit period counter, a shadowed duty register,
// and per-channel off / static-high / PWM selection with registered outputs.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_tick
);

  localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);

  logic [15:0] r_presc;
  logic [7:0]  r_cnt;
  logic [7:0]  r_duty_sh;
  logic        r_tick;
  logic [15:0] r_out;

  logic        w_step;
  logic        w_wrap;
  logic        w_pwm_sig;
  logic [15:0] w_en_out;
  logic [15:0] w_en_pwm;
  logic [15:0] w_out_d;

  assign w_step = (r_presc == DivLast);
  assign w_wrap = w_step && (r_cnt == 8'hFF);

  // 0xFF is forced high so full duty never drops for the cnt==255 slot.
  assign w_pwm_sig = (r_duty_sh == 8'hFF) || (r_cnt < r_duty_sh);

  assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign w_out_d  = w_en_out & (~w_en_pwm | {16{w_pwm_sig}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= 16'd0;
      r_cnt     <= 8'd0;
      r_duty_sh <= 8'd0;
      r_tick    <= 1'b0;
      r_out     <= 16'h0000;
    end else begin
      r_presc <= w_step ? 16'd0 : r_presc + 16'd1;
      if (w_step) begin
        r_cnt <= r_cnt + 8'd1;
      end
      // Duty only changes on a period boundary so a running period is never disturbed.
      if (w_wrap) begin
        r_duty_sh <= pwm_duty_cycle;
      end
      r_tick <= w_wrap;
      r_out  <= w_out_d;
    end
  end

  assign out         = r_out;
  assign period_tick = r_tick;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral (CLK_DIV=4): per-period expectations are queued at each period_tick
// and a monitor scores each period window's high-time, rise alignment and length.
module tb_pwm_peripheral;

  localparam int unsigned ClkDiv = 4;
  localparam int          Period = 256 * ClkDiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  eo_lo = '0, eo_hi = '0, ep_lo = '0, ep_hi = '0, duty = '0;
  logic [15:0] out;
  logic        period_tick;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0]        win;
    logic [15:0][10:0] high;
    logic [15:0]       first;
  } exp_t;

  exp_t sb_q[$];

  pwm_peripheral #(.CLK_DIV(ClkDiv)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_tick     (period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
  endtask

  // Expected high-time per channel for one full period with the given setup.
  function automatic exp_t mk(input int win, input logic [15:0] eo, input logic [15:0] ep,
                              input logic [7:0] d);
    exp_t e;
    int   h;
    e.win = 8'(win);
    for (int i = 0; i < 16; i++) begin
      if (!eo[i])          h = 0;
      else if (!ep[i])     h = Period;
      else if (d == 8'hFF) h = Period;
      else                 h = ClkDiv * int'(d);
      e.high[i]  = 11'(h);
      e.first[i] = (h > 0);
    end
    return e;
  endfunction

  task automatic wait_tick(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (period_tick) break;
      if (n >= 3 * Period) begin
        check("tick_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Duty for the window now starting is whatever sat on the input at the wrap.
  task automatic push_window(input int win, input logic [15:0] eo, input logic [15:0] ep);
    set_en(eo, ep);
    sb_q.push_back(mk(win, eo, ep, duty));
  endtask

  task automatic at_tick(input int win, input logic [15:0] eo, input logic [15:0] ep);
    int n;
    wait_tick(n);
    push_window(win, eo, ep);
  endtask

  // Monitor: a window spans the samples after one tick through the next tick inclusive.
  initial begin
    bit          open = 0;
    int          nsamp = 0;
    int          hc[16];
    logic [15:0] first = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (open && sb_q.size() > 0) e = sb_q.pop_front();
        open = 0;
      end else begin
        if (open) begin
          nsamp++;
          if (nsamp == 1) first = out;
          for (int i = 0; i < 16; i++) if (out[i]) hc[i]++;
        end
        if (period_tick) begin
          if (open) begin
            if (sb_q.size() == 0) begin
              check("window_has_expectation", 0, 1);
            end else begin
              e = sb_q.pop_front();
              check($sformatf("win%0d_period_len", e.win), nsamp, Period);
              check($sformatf("win%0d_rise_vector", e.win), int'(first), int'(e.first));
              for (int i = 0; i < 16; i++)
                check($sformatf("win%0d_ch%0d_high", e.win, i), hc[i], int'(e.high[i]));
            end
          end
          open  = 1;
          nsamp = 0;
          first = '0;
          for (int i = 0; i < 16; i++) hc[i] = 0;
        end
      end
    end
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt_a;
    int cnt_b;

    repeat (3) @(negedge clk);
    check("reset_out", int'(out), 0);
    check("reset_tick", int'(period_tick), 0);

    // Static enables appear exactly one clock later.
    rst = 1'b0;
    set_en(16'h00FF, 16'h0000);
    check("static_before_edge", int'(out), 0);
    @(negedge clk);
    check("static_one_clk", int'(out), 16'h00FF);

    // First period after reset runs with duty 0 even though 0x80 is requested.
    set_en(16'h00FF, 16'h0001);
    duty = 8'h80;
    @(negedge clk);
    cnt_a = 0;
    cnt_b = 0;
    repeat (500) begin
      @(negedge clk);
      if (out[0]) cnt_a++;
      if (out[15:1] != 15'h007F) cnt_b++;
    end
    check("first_period_pwm_low", cnt_a, 0);
    check("static_bits_hold", cnt_b, 0);
    wait_tick(n);
    check("first_tick_delay", n, Period - 502);
    push_window(1, 16'h0001, 16'h0001);

    at_tick(2, 16'h0001, 16'h0001);
    duty = 8'h00;
    at_tick(3, 16'h0001, 16'h0001);
    duty = 8'hFF;
    at_tick(4, 16'h0001, 16'h0001);
    at_tick(5, 16'h0001, 16'h0001);
    duty = 8'h40;
    at_tick(6, 16'h0001, 16'h0001);
    repeat (500) @(negedge clk);
    duty = 8'hC0;
    at_tick(7, 16'hFFFF, 16'hAAAA);
    duty = 8'h20;
    at_tick(8, 16'hFFFF, 16'hAAAA);

    // Reset mid-period: outputs clear asynchronously and the period is abandoned.
    repeat (300) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_out", int'(out), 0);
    check("rst_async_tick", int'(period_tick), 0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_out", int'(out), 0);
    end
    rst   = 1'b0;
    n     = 0;
    cnt_a = 0;
    cnt_b = 0;
    forever begin
      @(negedge clk);
      n++;
      if ((out & 16'hAAAA) != 16'h0000) cnt_a++;
      if ((out & 16'h5555) != 16'h5555) cnt_b++;
      if (period_tick) break;
      if (n >= 3 * Period) begin
        check("tick_timeout", 0, 1);
        break;
      end
    end
    check("rst_tick_spacing", n, Period);
    check("rst_pwm_low", cnt_a, 0);
    check("rst_static_high", cnt_b, 0);
    push_window(9, 16'hFFFF, 16'hAAAA);

    wait_tick(n);
    @(negedge clk);
    check("queue_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 Parameter: CLK_DIV, default 3000, clk cycles per PWM count step (legal range 1..65535).
REQ-002 clk  input  1  system clock; all state on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 en_reg_out_7_0  input  8  output enable, channels 7..0.
REQ-005 en_reg_out_15_8  input  8  output enable, channels 15..8.
REQ-006 en_reg_pwm_7_0  input  8  PWM mode select, channels 7..0.
REQ-007 en_reg_pwm_15_8  input  8  PWM mode select, channels 15..8.
REQ-008 pwm_duty_cycle  input  8  requested duty; high for duty/256 of period.
REQ-009 out  output  16  registered channel outputs.
REQ-010 period_tick  output  1  one-clk pulse marking the start of each PWM period.

Function
REQ-011 Register inputs are quasi-static, already in the clk domain, and SHALL be sampled directly with no synchronizers.
REQ-012 Prescaler: 16-bit counter counts 0..CLK_DIV-1, wraps to 0. step = (prescaler == CLK_DIV-1).
REQ-013 PWM counter: 8-bit pwm_cnt increments on step only, wraps 255 -> 0. Period = 256*CLK_DIV clk cycles.
REQ-014 Duty shadow: duty_sh loads pwm_duty_cycle only on the step where pwm_cnt wraps 255 -> 0. A mid-period duty write SHALL NOT alter the current period.
REQ-015 period_tick SHALL be 1 for exactly the clk cycle after the wrap step (pwm_cnt == 0 and prescaler == 0 after wrap). It is 0 otherwise.
REQ-016 pwm_sig = 1 when duty_sh == 8'hFF; otherwise pwm_sig = (pwm_cnt < duty_sh). This gives duty 0x00 -> constant 0 and 0xFF -> constant 1.
REQ-017 Channel map for each i in 0..15, with en_out/en_pwm formed as {15_8, 7_0}:
- en_out[i]=0 -> 0
- en_out[i]=1 and en_pwm[i]=0 -> 1
- en_out[i]=1 and en_pwm[i]=1 -> pwm_sig
REQ-018 out SHALL be registered from REQ-017, giving 1 clk latency from any input or counter change.
REQ-019 Enable and mode changes SHALL be unshadowed and take effect 1 clk after the change.
REQ-020 All PWM-mode channels SHALL share one counter and be phase-aligned; every enabled PWM channel rises in the same clk.
REQ-021 CLK_DIV = 1: step SHALL be asserted every cycle, and the period is 256 clks.

Reset
REQ-022 While rst=1: prescaler=0, pwm_cnt=0, duty_sh=0, out=16'h0000, period_tick=0, asynchronously.
REQ-023 After rst deasserts, counting SHALL start at the first clk edge.
REQ-024 The first period after reset SHALL use duty_sh=0, so PWM channels stay low. The new duty is loaded at the first wrap (256*CLK_DIV clks).
REQ-025 Reset mid-period SHALL abort the period immediately with no partial pulse afterwards.

Verification (CLK_DIV=4, period 1024 clks)
REQ-026 en_out=16'h00FF, en_pwm=0 -> out=16'h00FF one clk later, static.
REQ-027 en_out=en_pwm=16'h0001, duty=8'h80, after first wrap -> out[0] high 512 clks and low 512 clks per period; rises 1 clk after period_tick.
REQ-028 duty=8'h00 -> out[0] constant 0; duty=8'hFF -> out[0] constant 1 across a wrap, with no low glitch.
REQ-029 duty changed 8'h40 -> 8'hC0 mid-period -> current period stays 256 clks high; the next period is 768 clks high.
REQ-030 en_out=16'hFFFF, en_pwm=16'hAAAA, duty=8'h20 -> even bits constant 1; odd bits 128-clk pulses, all rising together.
REQ-031 rst pulsed mid-period -> out=0 immediately, no period_tick. The next period_tick occurs 1024 clks after release.
